// File: rtl/mkt_msg_parser.sv
// Market-message parser: decodes fixed-layout packets, keeps TRADE/CANCEL
// messages in a first-word-fall-through FIFO, and counts kept/dropped messages.
module mkt_msg_parser #(
  parameter int unsigned        PKT_W       = 128,
  parameter int unsigned        TYPE_W      = 8,
  parameter int unsigned        ID_W        = 16,
  parameter int unsigned        PRICE_W     = 32,
  parameter int unsigned        QTY_W       = 16,
  parameter int unsigned        DEPTH       = 4,
  parameter logic [TYPE_W-1:0]  TRADE_TYPE  = 8'h54,
  parameter logic [TYPE_W-1:0]  CANCEL_TYPE = 8'h58,
  parameter int unsigned        CNT_W       = 16
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [PKT_W-1:0]           in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [ID_W-1:0]            out_id,
  output logic [PRICE_W-1:0]         out_price,
  output logic [QTY_W-1:0]           out_qty,
  output logic                       out_cancel,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CNT_W-1:0]           msg_count,
  output logic [CNT_W-1:0]           drop_count,
  output logic [$clog2(DEPTH):0]     fifo_level
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam int unsigned LW        = AW + 1;
  localparam int unsigned FLD_W     = TYPE_W + ID_W + PRICE_W + QTY_W;
  localparam int unsigned ENT_W     = 1 + ID_W + PRICE_W + QTY_W;
  localparam int unsigned TYPE_MSB  = PKT_W - 1;
  localparam int unsigned ID_MSB    = TYPE_MSB - TYPE_W;
  localparam int unsigned PRICE_MSB = ID_MSB - ID_W;
  localparam int unsigned QTY_MSB   = PRICE_MSB - PRICE_W;
  localparam int unsigned RSV_W     = PKT_W - FLD_W;

  // Configuration sanity checks at elaboration
  if (FLD_W > PKT_W) begin : g_bad_fields
    $error("mkt_msg_parser: packet fields do not fit in PKT_W");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("mkt_msg_parser: DEPTH must be a power of 2 and at least 2");
  end

  // Reserved packet LSBs are intentionally ignored
  if (RSV_W > 0) begin : g_rsv
    logic unused_rsv;
    assign unused_rsv = ^in_data[RSV_W-1:0];
  end

  logic [TYPE_W-1:0]  fld_type;
  logic [ID_W-1:0]    fld_id;
  logic [PRICE_W-1:0] fld_price;
  logic [QTY_W-1:0]   fld_qty;
  logic               is_trade;
  logic               is_cancel;
  logic               keep;
  logic               accept;
  logic               push;
  logic               pop;
  logic               drop;

  logic [ENT_W-1:0]   mem_q [DEPTH];
  logic [ENT_W-1:0]   mem_d [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]      level_q, level_d;
  logic [CNT_W-1:0]   msg_cnt_q, msg_cnt_d;
  logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
  logic [ENT_W-1:0]   head;

  // Field extraction, MSB-first layout
  always_comb begin
    fld_type  = in_data[TYPE_MSB  -: TYPE_W];
    fld_id    = in_data[ID_MSB    -: ID_W];
    fld_price = in_data[PRICE_MSB -: PRICE_W];
    fld_qty   = in_data[QTY_MSB   -: QTY_W];
  end

  // Occupancy-based handshake flags
  assign in_ready  = (level_q != LW'(DEPTH));
  assign out_valid = (level_q != '0);

  // Classification and push/pop/drop decisions
  always_comb begin
    is_trade  = (fld_type == TRADE_TYPE) && (fld_qty != '0);
    is_cancel = (fld_type == CANCEL_TYPE);
    keep      = is_trade || is_cancel;
    accept    = in_valid && in_ready;
    push      = accept && keep;
    drop      = accept && !keep;
    pop       = out_valid && out_ready;
  end

  // Next-state for FIFO storage, pointers, occupancy and saturating counters
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    msg_cnt_d  = msg_cnt_q;
    drop_cnt_d = drop_cnt_q;

    if (push) begin
      mem_d[wr_ptr_q] = {is_cancel, fld_id, fld_price, fld_qty};
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    if (push && (msg_cnt_q != '1)) begin
      msg_cnt_d = msg_cnt_q + CNT_W'(1);
    end
    if (drop && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + CNT_W'(1);
    end
  end

  // State registers; reset clears FIFO contents so the head reads as zero
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      msg_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      msg_cnt_q  <= msg_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Head entry unpacking; sourced only from registered storage
  always_comb begin
    head       = mem_q[rd_ptr_q];
    out_cancel = head[ENT_W-1];
    out_id     = head[ENT_W-2 -: ID_W];
    out_price  = head[ENT_W-2-ID_W -: PRICE_W];
    out_qty    = head[QTY_W-1:0];
  end

  assign msg_count  = msg_cnt_q;
  assign drop_count = drop_cnt_q;
  assign fifo_level = level_q;

endmodule

// File: tb/tb_mkt_msg_parser.sv
// Directed testbench for mkt_msg_parser: a default instance plus a CNT_W=4
// instance sharing the same stimulus, used for counter saturation.
module tb_mkt_msg_parser;

  logic         clk;
  logic         rstn;
  logic [127:0] in_data;
  logic         in_valid;
  logic         out_ready;

  logic         in_ready;
  logic [15:0]  out_id;
  logic [31:0]  out_price;
  logic [15:0]  out_qty;
  logic         out_cancel;
  logic         out_valid;
  logic [15:0]  msg_count;
  logic [15:0]  drop_count;
  logic [2:0]   fifo_level;

  logic         s_in_ready;
  logic [15:0]  s_out_id;
  logic [31:0]  s_out_price;
  logic [15:0]  s_out_qty;
  logic         s_out_cancel;
  logic         s_out_valid;
  logic [3:0]   s_msg_count;
  logic [3:0]   s_drop_count;
  logic [2:0]   s_fifo_level;

  int checks = 0;
  int errors = 0;

  mkt_msg_parser dut (
    .clk(clk), .rstn(rstn), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_id(out_id), .out_price(out_price),
    .out_qty(out_qty), .out_cancel(out_cancel), .out_valid(out_valid),
    .out_ready(out_ready), .msg_count(msg_count), .drop_count(drop_count),
    .fifo_level(fifo_level)
  );

  mkt_msg_parser #(.CNT_W(4)) dut_sat (
    .clk(clk), .rstn(rstn), .in_data(in_data), .in_valid(in_valid),
    .in_ready(s_in_ready), .out_id(s_out_id), .out_price(s_out_price),
    .out_qty(s_out_qty), .out_cancel(s_out_cancel), .out_valid(s_out_valid),
    .out_ready(out_ready), .msg_count(s_msg_count), .drop_count(s_drop_count),
    .fifo_level(s_fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [127:0] mk(input logic [7:0] t, input logic [15:0] id,
                                      input logic [31:0] p, input logic [15:0] q);
    return {t, id, p, q, 56'hA5A5_5A5A_C3C3_3C};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    rstn = 1'b0;
    #2;
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    repeat (2) step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b exp 0", out_valid); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d exp 0", fifo_level); end
    checks++; if (msg_count !== 16'd0 || drop_count !== 16'd0) begin errors++; $display("FAIL reset_counts: got %0d/%0d exp 0/0", msg_count, drop_count); end
    checks++; if ({out_id, out_price, out_qty, out_cancel} !== 65'd0) begin errors++; $display("FAIL reset_outputs: got %h exp 0", {out_id, out_price, out_qty, out_cancel}); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b exp 1", in_ready); end
    rstn = 1'b1;
    step();
  endtask

  task automatic test_single_trade();
    do_reset();
    in_data = mk(8'h54, 16'h1234, 32'h0001_86A0, 16'h0064); in_valid = 1'b1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_pre_valid: got %0b exp 0", out_valid); end
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %0b exp 1", out_valid); end
    checks++; if (out_id !== 16'h1234) begin errors++; $display("FAIL single_id: got %h exp 1234", out_id); end
    checks++; if (out_price !== 32'd100000) begin errors++; $display("FAIL single_price: got %0d exp 100000", out_price); end
    checks++; if (out_qty !== 16'd100 || out_cancel !== 1'b0) begin errors++; $display("FAIL single_qty_cancel: got %0d/%0b exp 100/0", out_qty, out_cancel); end
    checks++; if (msg_count !== 16'd1 || fifo_level !== 3'd1) begin errors++; $display("FAIL single_count_level: got %0d/%0d exp 1/1", msg_count, fifo_level); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || fifo_level !== 3'd0) begin errors++; $display("FAIL single_pop: got %0b/%0d exp 0/0", out_valid, fifo_level); end
  endtask

  task automatic test_filter();
    do_reset();
    in_valid = 1'b1;
    in_data = mk(8'h41, 16'h0001, 32'd5, 16'd5);  step();
    in_data = mk(8'h54, 16'h0002, 32'd6, 16'd0);  step();
    checks++; if (out_valid !== 1'b0 || drop_count !== 16'd2) begin errors++; $display("FAIL filter_drops: got valid %0b drops %0d exp 0/2", out_valid, drop_count); end
    in_data = mk(8'h58, 16'h0007, 32'd9, 16'd0);  step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_cancel !== 1'b1) begin errors++; $display("FAIL filter_cancel: got %0b/%0b exp 1/1", out_valid, out_cancel); end
    checks++; if (out_id !== 16'h0007 || out_qty !== 16'd0) begin errors++; $display("FAIL filter_fields: got %h/%0d exp 0007/0", out_id, out_qty); end
    checks++; if (drop_count !== 16'd2 || msg_count !== 16'd1) begin errors++; $display("FAIL filter_counts: got %0d/%0d exp 2/1", drop_count, msg_count); end
    checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL filter_level: got %0d exp 1", fifo_level); end
  endtask

  task automatic test_backpressure();
    logic [15:0] exp_id;
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_data = mk(8'h54, 16'(16'h0100 + i), 32'(i), 16'(i + 1)); in_valid = 1'b1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_fill_ready%0d: got %0b exp 1", i, in_ready); end
      step();
    end
    in_data = mk(8'h54, 16'h0104, 32'd4, 16'd5);
    for (int i = 0; i < 2; i++) begin
      checks++; if (in_ready !== 1'b0 || fifo_level !== 3'd4) begin errors++; $display("FAIL bp_full%0d: got ready %0b level %0d exp 0/4", i, in_ready, fifo_level); end
      checks++; if (out_id !== 16'h0100) begin errors++; $display("FAIL bp_hold%0d: got %h exp 0100", i, out_id); end
      step();
    end
    out_ready = 1'b1;
    step();
    checks++; if (in_ready !== 1'b1 || fifo_level !== 3'd3 || out_id !== 16'h0101) begin errors++; $display("FAIL bp_first_pop: got ready %0b level %0d id %h exp 1/3/0101", in_ready, fifo_level, out_id); end
    step();
    checks++; if (fifo_level !== 3'd3 || out_id !== 16'h0102) begin errors++; $display("FAIL bp_pushpop4: got level %0d id %h exp 3/0102", fifo_level, out_id); end
    in_data = mk(8'h54, 16'h0105, 32'd5, 16'd6);
    step();
    in_valid = 1'b0;
    checks++; if (fifo_level !== 3'd3 || out_id !== 16'h0103) begin errors++; $display("FAIL bp_pushpop5: got level %0d id %h exp 3/0103", fifo_level, out_id); end
    exp_id = 16'h0104;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (out_valid !== 1'b1 || out_id !== exp_id || fifo_level !== 3'(2 - i)) begin errors++; $display("FAIL bp_drain%0d: got valid %0b id %h level %0d exp 1/%h/%0d", i, out_valid, out_id, fifo_level, exp_id, 2 - i); end
      exp_id = exp_id + 16'd1;
    end
    checks++; if (out_price !== 32'd5 || out_qty !== 16'd6) begin errors++; $display("FAIL bp_last_fields: got %0d/%0d exp 5/6", out_price, out_qty); end
    step();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || msg_count !== 16'd6) begin errors++; $display("FAIL bp_end: got valid %0b msgs %0d exp 0/6", out_valid, msg_count); end
  endtask

  task automatic test_streaming();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      in_data = mk(8'h54, 16'(i), 32'(1000 + i), 16'd1); in_valid = 1'b1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready%0d: got %0b exp 1", i, in_ready); end
      step();
      checks++; if (out_valid !== 1'b1 || out_id !== 16'(i) || out_price !== 32'(1000 + i) || fifo_level !== 3'd1) begin errors++; $display("FAIL stream_out%0d: got valid %0b id %0d price %0d level %0d exp 1/%0d/%0d/1", i, out_valid, out_id, out_price, fifo_level, i, 1000 + i); end
    end
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || fifo_level !== 3'd0) begin errors++; $display("FAIL stream_empty: got %0b/%0d exp 0/0", out_valid, fifo_level); end
    checks++; if (msg_count !== 16'd32) begin errors++; $display("FAIL stream_msgs: got %0d exp 32", msg_count); end
    checks++; if (s_msg_count !== 4'd15) begin errors++; $display("FAIL stream_msgs_sat: got %0d exp 15", s_msg_count); end
  endtask

  task automatic test_saturation();
    do_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_data = mk(8'h99, 16'(i), 32'd1, 16'd1);
      step();
      if (i == 14) begin
        checks++; if (s_drop_count !== 4'd15 || drop_count !== 16'd15) begin errors++; $display("FAIL sat_at15: got %0d/%0d exp 15/15", s_drop_count, drop_count); end
      end
    end
    in_valid = 1'b0;
    checks++; if (s_drop_count !== 4'd15) begin errors++; $display("FAIL sat_hold: got %0d exp 15", s_drop_count); end
    checks++; if (drop_count !== 16'd20) begin errors++; $display("FAIL sat_wide: got %0d exp 20", drop_count); end
    checks++; if (out_valid !== 1'b0 || msg_count !== 16'd0) begin errors++; $display("FAIL sat_no_push: got %0b/%0d exp 0/0", out_valid, msg_count); end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = mk(8'h54, 16'(16'h0A00 + i), 32'd77, 16'd3);
      step();
    end
    in_valid = 1'b0;
    checks++; if (fifo_level !== 3'd3) begin errors++; $display("FAIL mid_level: got %0d exp 3", fifo_level); end
    rstn = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || fifo_level !== 3'd0) begin errors++; $display("FAIL mid_async_fifo: got %0b/%0d exp 0/0", out_valid, fifo_level); end
    checks++; if (msg_count !== 16'd0 || drop_count !== 16'd0 || out_id !== 16'd0) begin errors++; $display("FAIL mid_async_cnt: got %0d/%0d/%h exp 0/0/0", msg_count, drop_count, out_id); end
    rstn = 1'b1;
    in_data = mk(8'h54, 16'hBEEF, 32'h42, 16'd9); in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_id !== 16'hBEEF || out_price !== 32'h42 || out_qty !== 16'd9) begin errors++; $display("FAIL mid_new: got %0b/%h/%h/%0d exp 1/beef/42/9", out_valid, out_id, out_price, out_qty); end
    checks++; if (fifo_level !== 3'd1 || msg_count !== 16'd1) begin errors++; $display("FAIL mid_new_cnt: got %0d/%0d exp 1/1", fifo_level, msg_count); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_no_stale: got %0b exp 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_single_trade();
    test_filter();
    test_backpressure();
    test_streaming();
    test_saturation();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
